// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl: sequencing controller for a WORDS x WIDTH NAND-latch
// bitcell array shared by two round-robin arbitrated requesters. Each access
// runs SETUP -> ACCESS -> HOLD so that r_w and data-in are stable whenever a
// row select is high.
// Optional build macro: BITCELL_CTRL_WRITE_VERIFY_EN adds a read-back pass
// after every write and flags mismatches on rsp_err.
module bitcell_array_ctrl #(
  parameter int WIDTH      = 8,
  parameter int WORDS      = 4,
  parameter int ADDR_W     = 2,
  parameter int ACC_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*WIDTH-1:0]    req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic [WORDS-1:0]      arr_sel,
  output logic                  arr_rw,
  output logic [WIDTH-1:0]      arr_din,
  input  logic [WIDTH-1:0]      arr_dout
);

  localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_HOLD    = 3'd3
`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
    ,
    S_VSETUP  = 3'd4,
    S_VACCESS = 3'd5,
    S_VHOLD   = 3'd6
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_acc_last;

  logic               r_last_grant;
  logic               r_owner;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_inrange;

  logic [WORDS-1:0]   r_sel;
  logic               r_rw;
  logic [WIDTH-1:0]   r_din;
  logic [1:0]         r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_rdata;
  logic               r_rsp_err;

  logic               w_gnt_idx;
  logic [1:0]         w_ready;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [WIDTH-1:0]   w_req_wdata;
  logic               w_addr_ok;
  logic [WORDS-1:0]   w_onehot;

  logic [WORDS-1:0]   w_sel_nxt;
  logic               w_rw_nxt;
  logic [WIDTH-1:0]   w_din_nxt;
  logic [1:0]         w_rsp_valid_nxt;
  logic [WIDTH-1:0]   w_rsp_rdata_nxt;
  logic               w_rsp_err_nxt;

  assign w_acc_last = (r_cnt == CNT_W'(ACC_CYCLES - 1));
  assign w_onehot   = {{(WORDS-1){1'b0}}, 1'b1} << r_addr;

  // Round-robin arbitration; ready only in IDLE for the granted valid requester
  always_comb begin
    if (req_valid == 2'b11) begin
      w_gnt_idx = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_gnt_idx = 1'b1;
    end else begin
      w_gnt_idx = 1'b0;
    end
    if ((r_state == S_IDLE) && req_valid[w_gnt_idx]) begin
      w_ready = w_gnt_idx ? 2'b10 : 2'b01;
    end else begin
      w_ready = 2'b00;
    end
    if (w_gnt_idx) begin
      w_req_addr  = req_addr[2*ADDR_W-1:ADDR_W];
      w_req_wdata = req_wdata[2*WIDTH-1:WIDTH];
    end else begin
      w_req_addr  = req_addr[ADDR_W-1:0];
      w_req_wdata = req_wdata[WIDTH-1:0];
    end
    w_xfer    = |w_ready;
    w_addr_ok = (32'(w_req_addr) < 32'(WORDS));
  end

  assign req_ready = w_ready;

  // State register and phase counter (counter restarts on every state change)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic for the access phase sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_xfer ? S_SETUP : S_IDLE;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: w_next = w_acc_last ? S_HOLD : S_ACCESS;
`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
      S_HOLD:    w_next = r_we ? S_VSETUP : S_IDLE;
      // Two cycles with r_w low before the read-back select rises
      S_VSETUP:  w_next = (r_cnt == CNT_W'(1)) ? S_VACCESS : S_VSETUP;
      S_VACCESS: w_next = w_acc_last ? S_VHOLD : S_VACCESS;
      S_VHOLD:   w_next = S_IDLE;
`else
      S_HOLD:   w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  // Next values of the registered array and response outputs
  always_comb begin
    w_sel_nxt       = {WORDS{1'b0}};
    w_rw_nxt        = r_rw;
    w_din_nxt       = r_din;
    w_rsp_valid_nxt = 2'b00;
    w_rsp_rdata_nxt = {WIDTH{1'b0}};
    w_rsp_err_nxt   = 1'b0;
    // r_w and data-in only move when leaving IDLE, while every sel is low
    if ((r_state == S_IDLE) && w_xfer) begin
      w_rw_nxt  = req_we[w_gnt_idx];
      w_din_nxt = req_we[w_gnt_idx] ? w_req_wdata : {WIDTH{1'b0}};
    end else begin
      w_rw_nxt  = r_rw;
      w_din_nxt = r_din;
    end
`ifdef BITCELL_CTRL_WRITE_VERIFY_EN
    if (((w_next == S_ACCESS) || (w_next == S_VACCESS)) && r_inrange) begin
      w_sel_nxt = w_onehot;
    end else begin
      w_sel_nxt = {WORDS{1'b0}};
    end
    if ((r_state == S_HOLD) && (w_next == S_VSETUP)) begin
      w_rw_nxt = 1'b0;
    end else begin
      w_rw_nxt = w_rw_nxt;
    end
    if ((r_state == S_ACCESS) && (w_next == S_HOLD) && !r_we) begin
      w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
      w_rsp_rdata_nxt = r_inrange ? arr_dout : {WIDTH{1'b0}};
      w_rsp_err_nxt   = !r_inrange;
    end else if ((r_state == S_VACCESS) && (w_next == S_VHOLD)) begin
      w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
      w_rsp_rdata_nxt = r_inrange ? arr_dout : {WIDTH{1'b0}};
      w_rsp_err_nxt   = !r_inrange || (arr_dout != r_din);
    end else begin
      w_rsp_valid_nxt = 2'b00;
    end
`else
    if ((w_next == S_ACCESS) && r_inrange) begin
      w_sel_nxt = w_onehot;
    end else begin
      w_sel_nxt = {WORDS{1'b0}};
    end
    if ((r_state == S_ACCESS) && (w_next == S_HOLD)) begin
      w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
      w_rsp_rdata_nxt = (r_inrange && !r_we) ? arr_dout : {WIDTH{1'b0}};
      w_rsp_err_nxt   = !r_inrange;
    end else begin
      w_rsp_valid_nxt = 2'b00;
    end
`endif
  end

  // Latch the accepted request and remember who was served last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_inrange    <= 1'b0;
    end else if (w_xfer) begin
      r_last_grant <= w_gnt_idx;
      r_owner      <= w_gnt_idx;
      r_we         <= req_we[w_gnt_idx];
      r_addr       <= w_req_addr;
      r_inrange    <= w_addr_ok;
    end
  end

  // Registered outputs so sel, r_w and data-in never glitch at the bitcells
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= {WORDS{1'b0}};
      r_rw        <= 1'b0;
      r_din       <= {WIDTH{1'b0}};
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= {WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_sel       <= w_sel_nxt;
      r_rw        <= w_rw_nxt;
      r_din       <= w_din_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign arr_sel   = r_sel;
  assign arr_rw    = r_rw;
  assign arr_din   = r_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
